// File: rtl/stopwatch_core_if.sv
// Button inputs and display outputs of the stopwatch core, bundled as one bus.
// The master side drives the raw buttons and observes the display value.
interface stopwatch_core_if;
   logic        btn_start_stop;
   logic        btn_clear;
   logic [31:0] num;
   logic        running;

   modport master (
      output btn_start_stop,
      output btn_clear,
      input  num,
      input  running
   );

   modport slave (
      input  btn_start_stop,
      input  btn_clear,
      output num,
      output running
   );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch core: synchronises and debounces two push-buttons, runs a
// HELLO/STOPPED/RUNNING/OVERFLOW state machine and a 0..9998 centisecond
// counter, and presents a registered display value plus a running flag.
module stopwatch_core #(
   parameter int TICK_DIV        = 1000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic             clk,
   input logic             rst,
   stopwatch_core_if.slave bus
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [13:0]      COUNT_MAX = 14'd9998;

   localparam logic [31:0] NUM_HELLO    = 32'd9999;
   localparam logic [31:0] NUM_OVERFLOW = 32'd10000;

   typedef enum logic [1:0] {
      HELLO,
      STOPPED,
      RUNNING,
      OVERFLOW
   } state_t;

   // Bit 0 carries start/stop, bit 1 carries clear throughout the button path.
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      acc_q, acc_d;
   logic [1:0]      press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   state_t          state_q, state_d;
   logic [13:0]     count_q, count_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [31:0]     num_q, num_d;
   logic            running_q, running_d;

   logic            ss_ev;
   logic            clr_ev;

   assign ss_ev  = press_q[0];
   assign clr_ev = press_q[1];

   // Synchroniser, debouncer and press-event flops; reset wipes all progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         acc_q       <= '0;
         press_q     <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         acc_q       <= acc_d;
         press_q     <= press_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
      end
   end

   // Accept a new level only after it has differed from the accepted level for
   // DEBOUNCE_CYCLES straight cycles; a rising acceptance yields a one-cycle press.
   always_comb begin
      sync1_d = {bus.btn_clear, bus.btn_start_stop};
      sync2_d = sync1_q;
      acc_d   = acc_q;
      press_d = '0;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != acc_q[i]) begin
            if (db_cnt_q[i] == DB_MAX) begin
               acc_d[i]   = sync2_q[i];
               press_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // State register together with the counter, prescaler and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= HELLO;
         count_q   <= '0;
         pre_q     <= '0;
         num_q     <= NUM_HELLO;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pre_q     <= pre_d;
         num_q     <= num_d;
         running_q <= running_d;
      end
   end

   // Next state: clear beats start/stop, and any button event beats a tick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pre_d   = pre_q;
      unique case (state_q)
         HELLO: begin
            if (clr_ev) begin
               state_d = STOPPED;
               count_d = '0;
            end else if (ss_ev) begin
               state_d = RUNNING;
               count_d = '0;
               pre_d   = '0;
            end
         end
         STOPPED: begin
            if (clr_ev) begin
               count_d = '0;
            end else if (ss_ev) begin
               state_d = RUNNING;
               pre_d   = '0;
            end
         end
         RUNNING: begin
            if (clr_ev) begin
               count_d = '0;
               pre_d   = '0;
            end else if (ss_ev) begin
               state_d = STOPPED;
            end else if (pre_q == PRE_MAX) begin
               pre_d = '0;
               if (count_q == COUNT_MAX) begin
                  state_d = OVERFLOW;
               end else begin
                  count_d = count_q + 14'd1;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         OVERFLOW: begin
            if (clr_ev) begin
               state_d = STOPPED;
               count_d = '0;
            end
         end
         default: begin
            state_d = HELLO;
            count_d = '0;
            pre_d   = '0;
         end
      endcase
   end

   // Display value and running flag, computed from the upcoming state so the
   // registered outputs change on the same edge as the state itself.
   always_comb begin
      num_d     = {18'd0, count_d};
      running_d = 1'b0;
      unique case (state_d)
         HELLO:    num_d = NUM_HELLO;
         STOPPED:  num_d = {18'd0, count_d};
         RUNNING: begin
            num_d     = {18'd0, count_d};
            running_d = 1'b1;
         end
         OVERFLOW: num_d = NUM_OVERFLOW;
         default:  num_d = NUM_HELLO;
      endcase
   end

   assign bus.num     = num_q;
   assign bus.running = running_q;

endmodule
